// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-buffer stage register.
// Covers the reset PC, the NOP encoding and the occupancy state encoding.
package pipe_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: payload, PC and the precomputed PC+STEP / PC+2*STEP.
// Loads only when load=1; resets to a NOP at PC_RESET.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int unsigned         DATA_W   = 32,
    parameter int unsigned         PC_W     = 32,
    parameter logic [PC_W-1:0]     PC_RESET = PC_W'(PC_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d_instr,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [PC_W-1:0]   d_pc4,
    input  logic [PC_W-1:0]   d_pc8,
    output logic [DATA_W-1:0] q_instr,
    output logic [PC_W-1:0]   q_pc,
    output logic [PC_W-1:0]   q_pc4,
    output logic [PC_W-1:0]   q_pc8
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_instr <= DATA_W'(NOP_INSTR);
            q_pc    <= PC_RESET;
            q_pc4   <= PC_RESET;
            q_pc8   <= PC_RESET;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_pc4   <= d_pc4;
            q_pc8   <= d_pc8;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with a two-entry skid buffer (head + skid),
// synchronous flush, PC+STEP precompute at enqueue and a saturating stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     DATA_W   = 32,
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] PC_RESET = PC_W'(PC_RESET_DEFAULT),
    parameter int unsigned     PC_STEP  = 4,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc4,
    output logic [PC_W-1:0]   out_pc8,
    output logic [DATA_W-1:0] out_instr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t state, state_nx;

    logic enq, deq;
    logic load_head, load_skid, head_from_skid;

    logic [PC_W-1:0]   in_pc4, in_pc8;
    logic [DATA_W-1:0] head_instr, skid_instr, head_d_instr;
    logic [PC_W-1:0]   head_pc4, head_pc8;
    logic [PC_W-1:0]   skid_pc, skid_pc4, skid_pc8;
    logic [PC_W-1:0]   head_d_pc, head_d_pc4, head_d_pc8;

    // in_ready comes from the state register only (plus reset), never from out_ready.
    assign in_ready  = reset && (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign occupancy = state;

    assign in_pc4 = in_pc + PC_W'(PC_STEP);
    assign in_pc8 = in_pc + PC_W'(2 * PC_STEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (enq) begin
                    state_nx  = ST_ONE;
                    load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (enq && deq) begin
                    load_head = 1'b1;
                end else if (enq) begin
                    state_nx  = ST_FULL;
                    load_skid = 1'b1;
                end else if (deq) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deq) begin
                    state_nx       = ST_ONE;
                    load_head      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
        // Flush wins over everything; suppressing the loads keeps out_pc* holding.
        if (flush) begin
            state_nx  = ST_EMPTY;
            load_head = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_comb begin
        if (head_from_skid) begin
            head_d_instr = skid_instr;
            head_d_pc    = skid_pc;
            head_d_pc4   = skid_pc4;
            head_d_pc8   = skid_pc8;
        end else begin
            head_d_instr = in_instr;
            head_d_pc    = in_pc;
            head_d_pc4   = in_pc4;
            head_d_pc8   = in_pc8;
        end
    end

    pipe_entry #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .PC_RESET (PC_RESET)
    ) u_head (
        .clk     (clk),
        .reset   (reset),
        .load    (load_head),
        .d_instr (head_d_instr),
        .d_pc    (head_d_pc),
        .d_pc4   (head_d_pc4),
        .d_pc8   (head_d_pc8),
        .q_instr (head_instr),
        .q_pc    (out_pc),
        .q_pc4   (head_pc4),
        .q_pc8   (head_pc8)
    );

    pipe_entry #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .PC_RESET (PC_RESET)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (load_skid),
        .d_instr (in_instr),
        .d_pc    (in_pc),
        .d_pc4   (in_pc4),
        .d_pc8   (in_pc8),
        .q_instr (skid_instr),
        .q_pc    (skid_pc),
        .q_pc4   (skid_pc4),
        .q_pc8   (skid_pc8)
    );

    assign out_pc4   = head_pc4;
    assign out_pc8   = head_pc8;
    assign out_instr = out_valid ? head_instr : DATA_W'(NOP_INSTR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a vector table for streaming/wrap cases plus
// hand sequences for back-pressure, flush, counter saturation and mid-stream reset.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_pc, out_pc4, out_pc8, out_instr;
    logic [31:0] out_pc_2, out_pc4_2, out_pc8_2, out_instr2;
    logic [1:0]  occupancy, occupancy2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc4(out_pc4), .out_pc8(out_pc8),
        .out_instr(out_instr), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_pc(out_pc_2), .out_pc4(out_pc4_2), .out_pc8(out_pc8_2),
        .out_instr(out_instr2), .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_pc8;
        logic        e_ird;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] ins(input logic [31:0] p);
        return {16'hC0DE, p[15:0]};
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic fl,
                                input logic ordy, input logic e_ov, input logic [31:0] e_pc,
                                input logic [31:0] e_pc4, input logic [31:0] e_pc8,
                                input logic e_ird, input logic [1:0] e_occ);
        vec_t r;
        r.v = v; r.pc = pc; r.fl = fl; r.ordy = ordy; r.e_ov = e_ov;
        r.e_pc = e_pc; r.e_pc4 = e_pc4; r.e_pc8 = e_pc8; r.e_ird = e_ird; r.e_occ = e_occ;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic ordy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins(pc);
        flush     = fl;
        out_ready = ordy;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Streaming at full rate, then wrap-around of pc4/pc8.
        for (int unsigned i = 0; i < 8; i++) begin
            tbl.push_back(mk(1'b1, 32'h3000 + 4*i, 1'b0, 1'b1, 1'b1,
                             32'h3000 + 4*i, 32'h3004 + 4*i, 32'h3008 + 4*i, 1'b1, 2'd1));
        end
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h301C, 32'h3020, 32'h3024, 1'b1, 2'd0));
        tbl.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1,
                         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0,
                         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 1'b1, 2'd0));

        tick();
        tick();
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h3000);
        chk("rst_out_pc8", out_pc8, 32'h3000);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].pc, tbl[k].fl, tbl[k].ordy);
            tick();
            chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
            chk($sformatf("v%0d_out_pc", k), out_pc, tbl[k].e_pc);
            chk($sformatf("v%0d_out_pc4", k), out_pc4, tbl[k].e_pc4);
            chk($sformatf("v%0d_out_pc8", k), out_pc8, tbl[k].e_pc8);
            chk($sformatf("v%0d_out_instr", k), out_instr, tbl[k].e_ov ? ins(tbl[k].e_pc) : 32'h0);
            chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].e_ird));
            chk($sformatf("v%0d_occ", k), 32'(occupancy), 32'(tbl[k].e_occ));
        end
        chk("stream_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure: fill to FULL, two stalled cycles, then drain in order.
        drive(1'b1, 32'h3000, 1'b0, 1'b0); tick();
        chk("bp1_occ", 32'(occupancy), 32'd1);
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h3004, 1'b0, 1'b0); tick();
        chk("bp2_occ", 32'(occupancy), 32'd2);
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h3008, 1'b0, 1'b0); tick();
        chk("bp3_stall", 32'(stall_cnt), 32'd1);
        tick();
        chk("bp4_stall", 32'(stall_cnt), 32'd2);
        chk("bp4_out_pc", out_pc, 32'h3000);
        chk("bp4_out_instr", out_instr, 32'hC0DE_3000);
        drive(1'b0, 32'h0, 1'b0, 1'b1); tick();
        chk("drain1_out_valid", 32'(out_valid), 32'd1);
        chk("drain1_out_pc", out_pc, 32'h3004);
        chk("drain1_out_pc4", out_pc4, 32'h3008);
        chk("drain1_out_instr", out_instr, 32'hC0DE_3004);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        chk("drain1_occ", 32'(occupancy), 32'd1);
        tick();
        chk("drain2_out_valid", 32'(out_valid), 32'd0);
        chk("drain2_out_pc_hold", out_pc, 32'h3004);
        chk("drain2_stall", 32'(stall_cnt), 32'd2);
        chk("drain2_stall2", 32'(stall_cnt2), 32'd2);

        // Flush while FULL with a simultaneous offer that must be discarded.
        drive(1'b1, 32'h3100, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h3104, 1'b0, 1'b0); tick();
        chk("ff_pre_occ", 32'(occupancy), 32'd2);
        drive(1'b1, 32'h3040, 1'b1, 1'b0); tick();
        chk("ff_occ", 32'(occupancy), 32'd0);
        chk("ff_out_valid", 32'(out_valid), 32'd0);
        chk("ff_out_instr", out_instr, 32'h0);
        chk("ff_out_pc_hold", out_pc, 32'h3100);
        chk("ff_stall", 32'(stall_cnt), 32'd3);
        drive(1'b0, 32'h0, 1'b0, 1'b1); tick();
        chk("ff_after_out_valid", 32'(out_valid), 32'd0);
        chk("ff_after_in_ready", 32'(in_ready), 32'd1);

        // Flush while ONE with an accepted-looking enqueue and a dequeue.
        drive(1'b1, 32'h3200, 1'b0, 1'b0); tick();
        chk("f1_out_pc", out_pc, 32'h3200);
        drive(1'b1, 32'h3204, 1'b1, 1'b1); tick();
        chk("f1_occ", 32'(occupancy), 32'd0);
        chk("f1_out_pc_hold", out_pc, 32'h3200);
        drive(1'b0, 32'h0, 1'b0, 1'b1); tick();
        chk("f1_after_out_valid", 32'(out_valid), 32'd0);
        chk("f1_stall", 32'(stall_cnt), 32'd3);

        // Counter saturation on the CNT_W=2 instance.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        chk("sat_clr", 32'(stall_cnt2), 32'd0);
        drive(1'b1, 32'h3300, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h3304, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h3308, 1'b0, 1'b0);
        for (int unsigned i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("sat%0d_wide", i), 32'(stall_cnt), i);
            chk($sformatf("sat%0d_narrow", i), 32'(stall_cnt2), (i > 3) ? 32'd3 : i);
        end

        // Asynchronous reset mid-stream with both entries held.
        chk("mid_pre_occ", 32'(occupancy), 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_pc", out_pc, 32'h3000);
        chk("mid_out_pc4", out_pc4, 32'h3000);
        chk("mid_out_instr", out_instr, 32'h0);
        chk("mid_stall", 32'(stall_cnt), 32'd0);
        chk("mid_stall2", 32'(stall_cnt2), 32'd0);
        chk("mid_occ", 32'(occupancy), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a two-entry skid buffer, used between any two stages of the five-stage MIPS core (F→D first, then D→E, E→M, M→W). It replaces the single-entry enable-gated stage register with a valid/ready handshake. It supports synchronous flush and full-throughput back-pressure without a combinational ready path, and precomputes PC+STEP and PC+2·STEP at enqueue for link and delay-slot use. It also counts upstream stall cycles for performance debug.

## Interface
- DATA_W, 32, width of the instruction/payload field
- PC_W, 32, width of PC fields
- PC_RESET, 32'h0000_3000, PC value loaded into all PC outputs at reset
- PC_STEP, 4, increment used for out_pc4 (out_pc8 = 2·PC_STEP)
- CNT_W, 16, width of stall counter
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (asserts immediately on 0, released synchronously by design convention upstream)
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept; registered, depends only on occupancy
- in_pc  in  PC_W  PC of incoming entry
- in_instr  in  DATA_W  payload
- flush  in  1  synchronous discard of all held and incoming entries
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head
- out_pc / out_pc4 / out_pc8  out  PC_W  head PC, PC+PC_STEP, PC+2·PC_STEP
- out_instr  out  DATA_W  head payload; forced to 0 (NOP) when out_valid=0
- occupancy  out  2  entries held (0,1,2)
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid=1 and in_ready=0

## Operation
- States: EMPTY (0), ONE (1), FULL (2). in_ready = (state != FULL).
- Enqueue = in_valid & in_ready; dequeue = out_valid & out_ready.
- Transitions (flush=0): EMPTY+enq→ONE; ONE+enq+!deq→FULL; ONE+!enq+deq→EMPTY; ONE+enq+deq→ONE (head replaced, zero bubble); FULL+deq→ONE (skid entry moves to head); FULL ignores in_valid.
- Strict FIFO order; skid entry is never presented before head.
- pc4/pc8 computed at enqueue from in_pc, modulo 2^PC_W (0xFFFF_FFFC+4 → 0x0000_0000).
- flush=1: next state EMPTY regardless of enq/deq; an enqueue in the same cycle is discarded; dequeue handshake in that cycle still completes downstream. Flush overrides all other events.
- When out_valid=0, out_pc* hold their last values; out_instr reads 0.
- stall_cnt increments when in_valid & !in_ready, saturates at 2^CNT_W−1, cleared only by reset; flush does not clear it.

## Timing
- Reset (reset=0, any time, including mid-transfer): state EMPTY, out_valid=0, in_ready=1 after reset release (0 while asserted), out_pc=out_pc4=out_pc8=PC_RESET, out_instr=0, occupancy=0, stall_cnt=0.
- Latency: entry enqueued at edge t is visible on out_* immediately after edge t (1 cycle in→out).
- Throughput: 1 entry/cycle sustained when out_ready=1.
- in_ready falls the cycle after reaching FULL; rises the cycle after a dequeue from FULL. No combinational path from out_ready to in_ready.
- Flush: out_valid=0 and occupancy=0 from the edge where flush is sampled.

## Structure
- Shared package pipe_pkg: PC_RESET default, NOP_INSTR (32'h0), state encoding constants ST_EMPTY/ST_ONE/ST_FULL.
- One sub-module natural: pipe_entry (payload + pc + pc4 + pc8 register with load enable), instantiated twice (head, skid).

## Test plan
- Reset mid-stream with occupancy=2 → immediately out_valid=0, out_pc=0x3000, out_pc4=0x3000, out_instr=0, stall_cnt=0.
- Stream 0x3000..0x301C with out_ready=1 → outputs in order, one per cycle, out_pc4=pc+4, out_pc8=pc+8, in_ready stays 1.
- out_ready=0 for 4 cycles under constant in_valid → occupancy 1→2, in_ready=0 from cycle 3, stall_cnt=2 after 4 cycles; release → entries 0x3000, 0x3004 drain in order, none lost or duplicated.
- flush while FULL with simultaneous in_valid (pc 0x3040) → next cycle occupancy=0, out_valid=0, 0x3040 never emitted.
- in_pc=0xFFFF_FFFC → out_pc4=0x0000_0000, out_pc8=0x0000_0004.
- CNT_W=2, hold back-pressure 6 cycles → stall_cnt saturates at 3.
